// File: rtl/io_responder.sv
// CPU-side memory-mapped IO window responder: UART TX/RX byte FIFOs, a
// free-running cycle counter with coherent byte-wise snapshot reads, and a program-exit latch.
module io_responder #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       io_en,
    input  logic [2:0] io_sel,
    input  logic       io_wr,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       prog_done,
    output logic [7:0] exit_code
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [2:0] SEL_DATA   = 3'd0;
    localparam logic [2:0] SEL_STATUS = 3'd1;
    localparam logic [2:0] SEL_CNT0   = 3'd2;
    localparam logic [2:0] SEL_CNT1   = 3'd3;
    localparam logic [2:0] SEL_EXIT   = 3'd4;
    localparam logic [2:0] SEL_CNT2   = 3'd5;
    localparam logic [2:0] SEL_CNT3   = 3'd6;

    logic        wr_req;
    logic        rd_req;
    logic        status_rd;

    logic [31:0] counter;
    logic [23:0] snapshot;

    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wp;
    logic [PW-1:0] tx_rp;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_drop;
    logic          tx_ovf;

    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wp;
    logic [PW-1:0] rx_rp;
    logic          rx_nonempty;
    logic          rx_full;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_drop;
    logic          rx_ovr;

    logic [7:0]    rd_data;

    assign wr_req    = io_en & io_wr;
    assign rd_req    = io_en & ~io_wr;
    assign status_rd = rd_req && (io_sel == SEL_STATUS);

    // TX FIFO: a pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_empty    = (tx_wp == tx_rp);
    assign tx_full     = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[PW-2:0] == tx_rp[PW-2:0]);
    assign tx_valid    = ~tx_empty;
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = wr_req && (io_sel == SEL_DATA);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
    assign tx_data     = tx_valid ? tx_mem[tx_rp[PW-2:0]] : 8'h00;

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wp[PW-2:0]] <= io_din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) begin
                tx_wp <= tx_wp + PW'(1);
            end
            if (tx_pop) begin
                tx_rp <= tx_rp + PW'(1);
            end
        end
    end

    // RX FIFO: a CPU pop from an empty FIFO returns zero and leaves any same-cycle arrival queued.
    assign rx_nonempty = (rx_wp != rx_rp);
    assign rx_full     = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[PW-2:0] == rx_rp[PW-2:0]);
    assign rx_pop      = rd_req && (io_sel == SEL_DATA) && rx_nonempty;
    assign rx_push     = rx_valid & (~rx_full | rx_pop);
    assign rx_drop     = rx_valid & rx_full & ~rx_pop;

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wp[PW-2:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) begin
                rx_wp <= rx_wp + PW'(1);
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + PW'(1);
            end
        end
    end

    // Sticky error flags: a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            tx_ovf <= tx_drop | (tx_ovf & ~status_rd);
            rx_ovr <= rx_drop | (rx_ovr & ~status_rd);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            counter <= '0;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    // Reading byte 0 freezes the upper bytes, so a multi-read sequence never tears on a carry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            snapshot <= '0;
        end else if (rd_req && (io_sel == SEL_CNT0)) begin
            snapshot <= counter[31:8];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (io_sel)
            SEL_DATA:   rd_data = rx_nonempty ? rx_mem[rx_rp[PW-2:0]] : 8'h00;
            SEL_STATUS: rd_data = {4'b0000, rx_ovr, tx_ovf, rx_nonempty, tx_full};
            SEL_CNT0:   rd_data = counter[7:0];
            SEL_CNT1:   rd_data = snapshot[7:0];
            SEL_CNT2:   rd_data = snapshot[15:8];
            SEL_CNT3:   rd_data = snapshot[23:16];
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            io_dout <= 8'h00;
        end else if (rd_req) begin
            io_dout <= rd_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prog_done <= 1'b0;
            exit_code <= 8'h00;
        end else if (wr_req && (io_sel == SEL_EXIT)) begin
            prog_done <= 1'b1;
            exit_code <= io_din;
        end
    end

endmodule
